// File: rtl/seq_detect_pkg.sv
// Shared types and limits for the serial pattern detector.
// Holds the FSM state enum and parameter range bounds.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    HUNT = 2'b10
  } seq_state_t;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;
  localparam int CNT_W_MIN   = 1;
  localparam int CNT_W_MAX   = 32;

endpackage

// File: rtl/seq_detect_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins).
// Ports: CLK, RST (async high), inc, clr -> q [W].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/seq_detect.sv
// Serial bit-pattern detector, runtime pattern, overlap mode.
// Ports: CLK, RST, en, din, pat_load, pat_in, overlap, cnt_clr
//        -> match (pulse), match_cnt (saturating), busy.
module seq_detect
  import seq_detect_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               en,
  input  logic               din,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] LAST = FW'(PAT_LEN - 1);

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
    $error("seq_detect: PAT_LEN out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt
    $error("seq_detect: CNT_W out of range");
  end

  seq_state_t         state_q, state_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               match_q, match_d;
  logic [PAT_LEN-1:0] hist_sh;
  logic               hit;

  assign hist_sh = {hist_q[PAT_LEN-2:0], din};
  assign hit     = (hist_sh == pat_q);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (pat_load) begin
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = FILL;
    end else begin
      unique case (state_q)
        IDLE: ;
        FILL: begin
          if (en) begin
            hist_d = hist_sh;
            fill_d = fill_q + FW'(1);
            if (fill_q == LAST) begin
              state_d = HUNT;
              match_d = hit;
            end
          end
        end
        HUNT: begin
          if (en) begin
            hist_d  = hist_sh;
            match_d = hit;
          end
        end
        default: state_d = IDLE;
      endcase
      // Non-overlap: a full fresh pattern is needed after any hit.
      if (match_d && !overlap) begin
        fill_d  = '0;
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .CLK(CLK),
    .RST(RST),
    .inc(match_d),
    .clr(cnt_clr),
    .q  (match_cnt)
  );

  assign match = match_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_seq_detect.sv
// Directed self-checking bench for seq_detect.
// Two instances: PAT_LEN=4/CNT_W=8 and PAT_LEN=2/CNT_W=2.
module tb_seq_detect;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat4 = '0;
  logic [1:0] pat2 = '0;
  logic       overlap = 1'b1;
  logic       cnt_clr = 1'b0;

  logic       m4, b4, m2, b2;
  logic [7:0] c4;
  logic [1:0] c2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  seq_detect #(.PAT_LEN(4), .CNT_W(8)) dut4 (
    .CLK(CLK), .RST(RST), .en(en), .din(din),
    .pat_load(pat_load), .pat_in(pat4),
    .overlap(overlap), .cnt_clr(cnt_clr),
    .match(m4), .match_cnt(c4), .busy(b4)
  );

  seq_detect #(.PAT_LEN(2), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .en(en), .din(din),
    .pat_load(pat_load), .pat_in(pat2),
    .overlap(overlap), .cnt_clr(cnt_clr),
    .match(m2), .match_cnt(c2), .busy(b2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic d,
                     input logic ld, input logic clr);
    en       = e;
    din      = d;
    pat_load = ld;
    cnt_clr  = clr;
    @(posedge CLK);
    #1;
    en       = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic smp(input logic d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic load();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic clr();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [6:0] stream = 7'b1011011;
  logic [6:0] exp_ov = 7'b0001001;
  logic [6:0] exp_no = 7'b0001000;

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_match", m4, 1'b0);
    chk("rst_cnt", c4, 8'd0);
    chk("rst_busy", b4, 1'b0);
    RST = 1'b0;

    smp(1); smp(0); smp(1); smp(1);
    chk("idle_match", m4, 1'b0);
    chk("idle_cnt", c4, 8'd0);
    chk("idle_busy", b4, 1'b0);

    pat4 = 4'b1011; pat2 = 2'b10; overlap = 1'b1;
    load();
    chk("load_busy", b4, 1'b1);
    chk("load_match", m4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      smp(stream[6-i]);
      chk($sformatf("ov_m%0d", i + 1), m4, exp_ov[6-i]);
    end
    chk("ov_cnt", c4, 8'd2);

    clr();
    chk("clr_cnt", c4, 8'd0);
    overlap = 1'b0;
    load();
    for (int i = 0; i < 7; i++) begin
      smp(stream[6-i]);
      chk($sformatf("no_m%0d", i + 1), m4, exp_no[6-i]);
    end
    chk("no_cnt", c4, 8'd1);

    overlap = 1'b1;
    pat2 = 2'b10;
    load();
    clr();
    chk("gap_clr", c2, 2'd0);
    smp(1);
    chk("gap_m1", m2, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("gap_m2", m2, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_m3", m2, 1'b0);
    smp(0);
    chk("gap_m4", m2, 1'b1);
    chk("gap_cnt", c2, 2'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_fall", m2, 1'b0);

    pat4 = 4'b1011;
    load();
    clr();
    smp(1); smp(0); smp(1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rl_prio", m4, 1'b0);
    chk("rl_busy", b4, 1'b1);
    smp(1);
    chk("rl_m1", m4, 1'b0);
    smp(1);
    chk("rl_m2", m4, 1'b0);
    smp(0);
    chk("rl_m3", m4, 1'b0);
    smp(1);
    chk("rl_m4", m4, 1'b0);
    smp(1);
    chk("rl_m5", m4, 1'b1);
    chk("rl_cnt", c4, 8'd1);

    pat2 = 2'b11; pat4 = 4'b1111; overlap = 1'b1;
    load();
    clr();
    chk("sat_c0", c2, 2'd0);
    smp(1);
    chk("sat_m1", m2, 1'b0);
    smp(1);
    chk("sat_m2", m2, 1'b1);
    chk("sat_c2", c2, 2'd1);
    smp(1);
    chk("sat_m3", m2, 1'b1);
    chk("sat_c3", c2, 2'd2);
    smp(1);
    chk("sat_c4", c2, 2'd3);
    smp(1);
    chk("sat_c5", c2, 2'd3);
    smp(1);
    chk("sat_m6", m2, 1'b1);
    chk("sat_c6", c2, 2'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clrhit_m", m2, 1'b1);
    chk("clrhit_c", c2, 2'd0);

    chk("hunt_m4", m4, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_m4", m4, 1'b0);
    chk("arst_c4", c4, 8'd0);
    chk("arst_b4", b4, 1'b0);
    chk("arst_m2", m2, 1'b0);
    chk("arst_b2", b2, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp(1);
      chk($sformatf("post_m%0d", i), m4, 1'b0);
    end
    chk("post_busy", b4, 1'b0);
    load();
    chk("post_load", b4, 1'b1);
    smp(1); smp(1); smp(1); smp(1);
    chk("post_hit", m4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
